// File: rtl/perceptron_classifier_if.sv
// Signal bundle between the trainer/sample source and perceptron_classifier.
// The master drives weights, samples and out_ready; the slave (classifier) drives results.
interface perceptron_classifier_if #(
    parameter int W_W   = 14,
    parameter int X_W   = 7,
    parameter int CNT_W = 8
);
    localparam int ACC_W = W_W + X_W + 1;

    logic                    train_ready;
    logic signed [W_W-1:0]   w1_in;
    logic signed [W_W-1:0]   w2_in;
    logic signed [W_W-1:0]   bias_in;
    logic                    weights_vld;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [X_W-1:0]   x1;
    logic signed [X_W-1:0]   x2;
    logic signed [1:0]       t;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] y;
    logic signed [1:0]       class_out;
    logic                    mismatch;
    logic [CNT_W-1:0]        sample_cnt;
    logic [CNT_W-1:0]        err_cnt;

    modport master (
        output train_ready, w1_in, w2_in, bias_in, in_valid, x1, x2, t, out_ready,
        input  weights_vld, in_ready, out_valid, y, class_out, mismatch, sample_cnt, err_cnt
    );

    modport slave (
        input  train_ready, w1_in, w2_in, bias_in, in_valid, x1, x2, t, out_ready,
        output weights_vld, in_ready, out_valid, y, class_out, mismatch, sample_cnt, err_cnt
    );
endinterface

// File: rtl/perceptron_classifier.sv
// Perceptron inference: y = bias + w1*x1 + w2*x2 on one shared multiplier, 4 cycles per sample.
// Define CLS_ERR_CNT_EN to keep the target register, mismatch flag and saturating err_cnt.
module perceptron_classifier #(
    parameter int W_W   = 14,
    parameter int X_W   = 7,
    parameter int CNT_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    perceptron_classifier_if.slave bus
);
    localparam int ACC_W = W_W + X_W + 1;
    localparam int PRD_W = W_W + X_W;
    localparam logic signed [1:0] CLS_POS = 2'sb01;
    localparam logic signed [1:0] CLS_NEG = 2'sb11;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, MUL1, MUL2, RES} state_t;

    state_t                  state, state_nxt;
    logic signed [W_W-1:0]   w1_r, w2_r, bias_r;
    logic signed [X_W-1:0]   x1_r, x2_r;
    logic signed [ACC_W-1:0] acc;
    logic signed [1:0]       class_r;
    logic [CNT_W-1:0]        sample_cnt_r;

    logic signed [W_W-1:0]   mul_a;
    logic signed [X_W-1:0]   mul_b;
    logic signed [PRD_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no branch leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (state != IDLE && !bus.train_ready) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.train_ready) state_nxt = LOAD;
                LOAD:    state_nxt = WAIT;
                WAIT:    if (bus.in_valid) state_nxt = MUL1;
                MUL1:    state_nxt = MUL2;
                MUL2:    state_nxt = RES;
                RES:     if (bus.out_ready) state_nxt = WAIT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The single multiplier serves w1*x1 in MUL1 and w2*x2 otherwise.
    assign mul_a   = (state == MUL1) ? w1_r : w2_r;
    assign mul_b   = (state == MUL1) ? x1_r : x2_r;
    assign prod    = mul_a * mul_b;
    assign acc_sum = acc + {{(ACC_W-PRD_W){prod[PRD_W-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: plain registers, no RAM, so every datapath register takes the async reset.
        if (rst) begin
            w1_r         <= '0;
            w2_r         <= '0;
            bias_r       <= '0;
            x1_r         <= '0;
            x2_r         <= '0;
            acc          <= '0;
            class_r      <= '0;
            sample_cnt_r <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            case (state)
                LOAD: begin
                    w1_r         <= bus.w1_in;
                    w2_r         <= bus.w2_in;
                    bias_r       <= bus.bias_in;
                    sample_cnt_r <= '0;
                end
                WAIT: if (bus.in_valid) begin
                    x1_r <= bus.x1;
                    x2_r <= bus.x2;
                    acc  <= {{(ACC_W-W_W){bias_r[W_W-1]}}, bias_r};
                end
                MUL1: acc <= acc_sum;
                MUL2: begin
                    acc     <= acc_sum;
                    class_r <= acc_sum[ACC_W-1] ? CLS_NEG : CLS_POS;
                end
                RES: if (bus.out_ready) sample_cnt_r <= sample_cnt_r + CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef CLS_ERR_CNT_EN
    logic             t_neg;
    logic             mismatch_r;
    logic [CNT_W-1:0] err_cnt_r;

    // Only the sign of t matters, so a single bit is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_neg      <= 1'b0;
            mismatch_r <= 1'b0;
            err_cnt_r  <= '0;
        end else begin
            case (state)
                LOAD: err_cnt_r <= '0;
                WAIT: if (bus.in_valid) t_neg <= bus.t[1];
                MUL2: mismatch_r <= (acc_sum[ACC_W-1] != t_neg);
                RES:  if (bus.out_ready && mismatch_r && err_cnt_r != '1)
                          err_cnt_r <= err_cnt_r + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign bus.mismatch = mismatch_r;
    assign bus.err_cnt  = err_cnt_r;
`else
    assign bus.mismatch = 1'b0;
    assign bus.err_cnt  = '0;
`endif

    assign bus.weights_vld = (state == WAIT) || (state == MUL1) || (state == MUL2) || (state == RES);
    assign bus.in_ready    = (state == WAIT);
    assign bus.out_valid   = (state == RES);
    assign bus.y           = acc;
    assign bus.class_out   = class_r;
    assign bus.sample_cnt  = sample_cnt_r;
endmodule

// File: tb/tb_perceptron_classifier.sv
// Randomized bench for perceptron_classifier against an integer-arithmetic reference model.
// Expectations for mismatch/err_cnt follow whether CLS_ERR_CNT_EN is defined.
module tb_perceptron_classifier;
  localparam int W_W   = 14;
  localparam int X_W   = 7;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  perceptron_classifier_if #(.W_W(W_W), .X_W(X_W), .CNT_W(CNT_W)) bus ();

  perceptron_classifier #(.W_W(W_W), .X_W(X_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: latched weights and running counters.
  longint m_w1, m_w2, m_b;
  int     m_samples, m_errs;

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_sample_cnt"}, bus.sample_cnt, m_samples);
    check({tag, "_err_cnt"}, bus.err_cnt, m_errs);
  endtask

  // Drop train_ready (leaving to IDLE), then present new weights and reload.
  task automatic load_weights(input longint w1, input longint w2, input longint b);
    bus.train_ready = 1'b0;
    tick();
    check("idle_weights_vld", bus.weights_vld, 0);
    check("idle_in_ready", bus.in_ready, 0);
    check("idle_out_valid", bus.out_valid, 0);
    check_counters("idle_hold");
    bus.w1_in = W_W'(w1);
    bus.w2_in = W_W'(w2);
    bus.bias_in = W_W'(b);
    bus.train_ready = 1'b1;
    tick();
    check("load_weights_vld", bus.weights_vld, 0);
    check("load_in_ready", bus.in_ready, 0);
    tick();
    m_w1 = w1; m_w2 = w2; m_b = b;
    m_samples = 0; m_errs = 0;
    check("wait_weights_vld", bus.weights_vld, 1);
    check("wait_in_ready", bus.in_ready, 1);
    check_counters("load_clear");
    // Weight inputs are ignored after LOAD; scramble them.
    bus.w1_in = W_W'($urandom);
    bus.w2_in = W_W'($urandom);
    bus.bias_in = W_W'($urandom);
  endtask

  task automatic run_sample(input logic signed [X_W-1:0] x1, input logic signed [X_W-1:0] x2,
                            input logic [1:0] t, input int hold);
    longint ey;
    int ecls, et, emis;
    ey   = m_b + m_w1 * x1 + m_w2 * x2;
    ecls = (ey >= 0) ? 1 : -1;
    et   = t[1] ? -1 : 1;
`ifdef CLS_ERR_CNT_EN
    emis = (ecls != et) ? 1 : 0;
`else
    emis = 0;
`endif
    check("pre_in_ready", bus.in_ready, 1);
    bus.x1 = x1; bus.x2 = x2; bus.t = t;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    tick();
    bus.in_valid = 1'b0;
    bus.x1 = X_W'($urandom); bus.x2 = X_W'($urandom); bus.t = 2'($urandom);
    check("lat1_out_valid", bus.out_valid, 0);
    check("busy_in_ready", bus.in_ready, 0);
    tick();
    check("lat2_out_valid", bus.out_valid, 0);
    tick();
    check("lat3_out_valid", bus.out_valid, 1);
    check("y", bus.y, ey);
    check("class_out", bus.class_out, ecls);
    check("mismatch", bus.mismatch, emis);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_y", bus.y, ey);
      check("bp_class", bus.class_out, ecls);
      check("bp_in_ready", bus.in_ready, 0);
      check_counters("bp");
    end
    bus.out_ready = 1'b1;
    tick();
    m_samples = (m_samples + 1) % (CNT_MAX + 1);
    if (emis != 0 && m_errs < CNT_MAX) m_errs++;
    check("post_out_valid", bus.out_valid, 0);
    check("post_in_ready", bus.in_ready, 1);
    check_counters("post");
  endtask

  initial begin
    logic signed [X_W-1:0] rx1, rx2;
    logic [1:0]            rt;
    longint                ry;

    rst = 1'b1;
    bus.train_ready = 1'b0;
    bus.w1_in = '0; bus.w2_in = '0; bus.bias_in = '0;
    bus.in_valid = 1'b0; bus.x1 = '0; bus.x2 = '0; bus.t = '0;
    bus.out_ready = 1'b1;
    m_w1 = 0; m_w2 = 0; m_b = 0; m_samples = 0; m_errs = 0;
    tick();
    tick();
    check("rst_weights_vld", bus.weights_vld, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y", bus.y, 0);
    check("rst_class", bus.class_out, 0);
    check("rst_mismatch", bus.mismatch, 0);
    check_counters("rst");
    rst = 1'b0;

    // Directed cases with w1=2, w2=-3, bias=1.
    load_weights(2, -3, 1);
    run_sample(5, 2, 2'b01, 0);
    run_sample(-4, 3, 2'b01, 0);
    run_sample(1, 1, 2'b11, 0);
    run_sample(3, -7, 2'b11, 5);

    // Extremes: largest magnitudes in both directions.
    load_weights(-8192, -8192, -8192);
    run_sample(-64, -64, 2'b01, 0);
    run_sample(63, 63, 2'b01, 0);

    // Retrain during MUL1: the in-flight result must never appear.
    bus.x1 = 7'sd10; bus.x2 = 7'sd10; bus.t = 2'b01;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.train_ready = 1'b0;
    tick();
    check("retrain_weights_vld", bus.weights_vld, 0);
    for (int i = 0; i < 4; i++) begin
      check("retrain_out_valid", bus.out_valid, 0);
      check("retrain_in_ready", bus.in_ready, 0);
      tick();
    end
    check_counters("retrain_hold");

    // Random weights and samples, occasional backpressure; t may be 0 or 2.
    load_weights(longint'($signed(W_W'($urandom))), longint'($signed(W_W'($urandom))),
                 longint'($signed(W_W'($urandom))));
    for (int n = 0; n < 40; n++) begin
      rx1 = X_W'($urandom);
      rx2 = X_W'($urandom);
      rt  = 2'($urandom);
      run_sample(rx1, rx2, rt, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Forced mismatches: drives err_cnt to saturation and sample_cnt past its wrap.
    load_weights(longint'($signed(W_W'($urandom))), longint'($signed(W_W'($urandom))),
                 longint'($signed(W_W'($urandom))));
    for (int n = 0; n < CNT_MAX + 6; n++) begin
      rx1 = X_W'($urandom);
      rx2 = X_W'($urandom);
      ry  = m_b + m_w1 * rx1 + m_w2 * rx2;
      rt  = (ry >= 0) ? 2'b11 : 2'b01;
      run_sample(rx1, rx2, rt, 0);
    end

    // Asynchronous reset mid-sample clears outputs without waiting for an edge.
    bus.x1 = 7'sd5; bus.x2 = 7'sd5; bus.t = 2'b01;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    m_samples = 0; m_errs = 0;
    check("arst_weights_vld", bus.weights_vld, 0);
    check("arst_y", bus.y, 0);
    check_counters("arst");
    tick();
    rst = 1'b0;
    bus.train_ready = 1'b0;
    tick();
    check("arst_out_valid", bus.out_valid, 0);
    load_weights(2, -3, 1);
    run_sample(5, 2, 2'b01, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
